rf_delay_fetch: RTL and testbench



---
 rtl/rf_delay_fetch.sv | 174 +++++++++++++++++
 tb/tb_rf_delay_fetch.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rf_delay_fetch.sv
// rf_delay_fetch: per-pixel delay-and-fetch stage feeding the MEBRA beamformer.
// Holds one frame of RF samples per channel (split into even/odd banks so that
// s[d] and s[d+1] are read together) plus a per-channel delay table, and on
// start streams one delay-corrected sample per channel per cycle.
// Build option: define RF_INTERP_EN for quarter-sample linear interpolation;
// without it the nearest of s[d] / s[d+1] is selected. Latency is identical.
//
// state | meaning
// IDLE  | waiting for start; sample and delay writes accepted
// LOAD  | bf_start pulse to the downstream core; channel 0 issued
// FETCH | one channel issued into the pipeline per cycle
// DRAIN | pipeline emptying; leaves when done is pulsed
module rf_delay_fetch #(
  parameter int CHANNELS  = 128,
  parameter int CH_BITS   = 8,
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  input  logic                        wr_en,
  input  logic [CH_BITS-1:0]          wr_ch,
  input  logic [ADDR_BITS-1:0]        wr_addr,
  input  logic signed [15:0]          wr_data,
  input  logic                        dly_we,
  input  logic [CH_BITS-1:0]          dly_ch,
  input  logic [ADDR_BITS+1:0]        dly_val,
  output logic                        bf_start,
  output logic signed [15:0]          rf_out,
  output logic                        rf_valid,
  output logic                        done
);

  localparam int CH_IDX     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int HALF_BITS  = ADDR_BITS - 1;
  localparam int BANK_WORDS = CHANNELS * (DEPTH / 2);

  typedef enum logic [1:0] {IDLE, LOAD, FETCH, DRAIN} state_t;

  state_t state, state_nx;
  logic [CH_BITS-1:0] ch_cnt;
  logic issue, last_issue;

  logic signed [15:0] bank_even [BANK_WORDS];
  logic signed [15:0] bank_odd  [BANK_WORDS];
  logic [ADDR_BITS+1:0] dly_tab [CHANNELS];

  logic wr_ok, dly_ok;

  // stage 1
  logic v1, last1;
  logic [CH_IDX-1:0] ch1;
  logic [ADDR_BITS+1:0] dly_q;
  // stage 2
  logic v2, last2;
  logic signed [15:0] s_even_q, s_odd_q;
  logic d_odd_q, oob_q;
  logic [1:0] f_q;
  // stage 3
  logic last3;

  logic [ADDR_BITS-1:0] d;
  logic [HALF_BITS-1:0] odd_addr, even_addr;
  logic signed [15:0] s0, s1, sample;

  assign busy     = (state != IDLE);
  assign bf_start = (state == LOAD);

  // Out-of-range channel indices are dropped rather than aliased onto real channels.
  assign wr_ok  = wr_en  && !busy && ({1'b0, wr_ch}  < (CH_BITS+1)'(CHANNELS));
  assign dly_ok = dly_we && !busy && ({1'b0, dly_ch} < (CH_BITS+1)'(CHANNELS));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic and channel issue strobe.
  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    last_issue = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD, FETCH: begin
        issue      = 1'b1;
        last_issue = (ch_cnt == CH_BITS'(CHANNELS - 1));
        state_nx   = last_issue ? DRAIN : FETCH;
      end
      DRAIN: if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Channel issue counter, cleared whenever the FSM is idle.
  always_ff @(posedge clk) begin
    if (!rst || state == IDLE) ch_cnt <= '0;
    else if (issue)            ch_cnt <= ch_cnt + 1'b1;
  end

  // Sample banks and delay table; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_addr[0]) bank_odd [{wr_ch[CH_IDX-1:0], wr_addr[ADDR_BITS-1:1]}] <= wr_data;
      else            bank_even[{wr_ch[CH_IDX-1:0], wr_addr[ADDR_BITS-1:1]}] <= wr_data;
    end
    if (dly_ok) dly_tab[dly_ch[CH_IDX-1:0]] <= dly_val;
  end

  // Pipeline control flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1 <= 1'b0; last1 <= 1'b0;
      v2 <= 1'b0; last2 <= 1'b0;
      rf_valid <= 1'b0; last3 <= 1'b0;
      done <= 1'b0;
    end else begin
      v1 <= issue;  last1 <= last_issue;
      v2 <= v1;     last2 <= last1;
      rf_valid <= v2; last3 <= last2;
      done <= rf_valid && last3;
    end
  end

  // For odd d, s[d] comes from the odd bank and s[d+1] from the next even word.
  always_comb begin
    d         = dly_q[ADDR_BITS+1:2];
    odd_addr  = d[ADDR_BITS-1:1];
    even_addr = d[ADDR_BITS-1:1] + HALF_BITS'(d[0]);
  end

  // Stage 1 delay read, stage 2 bank reads.
  always_ff @(posedge clk) begin
    ch1      <= ch_cnt[CH_IDX-1:0];
    dly_q    <= dly_tab[ch_cnt[CH_IDX-1:0]];
    s_even_q <= bank_even[{ch1, even_addr}];
    s_odd_q  <= bank_odd [{ch1, odd_addr}];
    d_odd_q  <= d[0];
    f_q      <= dly_q[1:0];
    oob_q    <= (d == ADDR_BITS'(DEPTH - 1));
  end

`ifdef RF_INTERP_EN
  logic signed [16:0] diff;
  logic signed [18:0] prod;

  // Quarter-sample linear interpolation; the floor shift keeps the result between s0 and s1.
  always_comb begin
    s0     = d_odd_q ? s_odd_q  : s_even_q;
    s1     = d_odd_q ? s_even_q : s_odd_q;
    diff   = 17'(s1) - 17'(s0);
    prod   = 19'(diff) * 19'(signed'({1'b0, f_q}));
    sample = 16'(19'(s0) + (prod >>> 2));
  end
`else
  // Nearest-sample selection: fractions of half a sample or more round up.
  always_comb begin
    s0     = d_odd_q ? s_odd_q  : s_even_q;
    s1     = d_odd_q ? s_even_q : s_odd_q;
    sample = (f_q < 2'd2) ? s0 : s1;
  end
`endif

  // Stage 3 output register; zero outside valid slots and for out-of-range delays.
  always_ff @(posedge clk) begin
    if (!rst)              rf_out <= '0;
    else if (v2 && !oob_q) rf_out <= sample;
    else                   rf_out <= '0;
  end

endmodule

// File: tb/tb_rf_delay_fetch.sv
// Directed bench for rf_delay_fetch: stream timing, interpolation/nearest
// selection, out-of-range delay, mid-stream disturbance and mid-stream reset.
module tb_rf_delay_fetch;
  localparam int CHANNELS  = 128;
  localparam int CH_BITS   = 8;
  localparam int DEPTH     = 1024;
  localparam int ADDR_BITS = 10;

  logic clk, rst, start, busy, wr_en, dly_we, bf_start, rf_valid, done;
  logic [CH_BITS-1:0] wr_ch, dly_ch;
  logic [ADDR_BITS-1:0] wr_addr;
  logic signed [15:0] wr_data, rf_out;
  logic [ADDR_BITS+1:0] dly_val;

  int errors = 0;
  int checks = 0;
  int exp_v [CHANNELS];

  rf_delay_fetch #(.CHANNELS(CHANNELS), .CH_BITS(CH_BITS), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
    .dly_we(dly_we), .dly_ch(dly_ch), .dly_val(dly_val),
    .bf_start(bf_start), .rf_out(rf_out), .rf_valid(rf_valid), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_sample(input int ch, input int n, input int val);
    wr_en = 1'b1; wr_ch = CH_BITS'(ch); wr_addr = ADDR_BITS'(n); wr_data = 16'(val);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr_dly(input int ch, input int val);
    dly_we = 1'b1; dly_ch = CH_BITS'(ch); dly_val = (ADDR_BITS+2)'(val);
    tick();
    dly_we = 1'b0;
  endtask

  // mode 0: plain run, 1: start/writes pulsed mid-stream, 2: reset at S+20
  task automatic run_pixel(input int mode, input string name);
    int bfs = 0, dones = 0, bad_valid = 0, bad_zero = 0;
    bit aborted = 0;
    start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0; dly_we = 1'b0;
    chk({name, " bf_start@S+1"}, int'(bf_start), 1);
    chk({name, " busy@S+1"}, int'(busy), 1);
    for (int c = 2; c <= CHANNELS + 4; c++) begin
      if (mode == 1 && c == 20) begin
        start = 1'b1; wr_en = 1'b1; wr_ch = 8'd100; wr_addr = 10'd10; wr_data = -16'sd999;
        dly_we = 1'b1; dly_ch = 8'd100; dly_val = '0;
      end
      if (mode == 2 && c == 21) rst = 1'b0;
      tick();
      start = 1'b0; wr_en = 1'b0; dly_we = 1'b0;
      if (mode == 2 && c == 21) begin
        chk({name, " rf_out after rst"}, int'(rf_out), 0);
        chk({name, " rf_valid after rst"}, int'(rf_valid), 0);
        chk({name, " busy after rst"}, int'(busy), 0);
        chk({name, " bf_start after rst"}, int'(bf_start), 0);
        chk({name, " done after rst"}, int'(done), 0);
        rst = 1'b1;
        for (int i = 0; i < CHANNELS + 8; i++) begin
          tick();
          if (done) dones++;
          if (busy || rf_valid) bad_valid++;
        end
        chk({name, " no done after rst"}, dones, 0);
        chk({name, " quiet after rst"}, bad_valid, 0);
        aborted = 1;
        break;
      end
      if (bf_start) bfs++;
      if (c >= 4 && c < 4 + CHANNELS) begin
        if (!rf_valid) bad_valid++;
        chk($sformatf("%s ch%0d", name, c - 4), int'(rf_out), exp_v[c - 4]);
      end else if (rf_valid || rf_out != 0) begin
        bad_zero++;
      end
      if (c < CHANNELS + 4 && done) dones++;
      if (c == CHANNELS + 4) begin
        chk({name, " done@S+4+C"}, int'(done), 1);
        chk({name, " busy@S+4+C"}, int'(busy), 1);
      end
    end
    if (!aborted) begin
      chk({name, " extra bf_start"}, bfs, 0);
      chk({name, " early done"}, dones, 0);
      chk({name, " valid gaps"}, bad_valid, 0);
      chk({name, " nonzero idle out"}, bad_zero, 0);
      tick();
      chk({name, " busy@S+5+C"}, int'(busy), 0);
      chk({name, " done@S+5+C"}, int'(done), 0);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; wr_en = 1'b0; dly_we = 1'b0;
    wr_ch = '0; wr_addr = '0; wr_data = '0; dly_ch = '0; dly_val = '0;
    repeat (3) tick();
    chk("reset busy", int'(busy), 0);
    chk("reset bf_start", int'(bf_start), 0);
    chk("reset rf_out", int'(rf_out), 0);
    chk("reset rf_valid", int'(rf_valid), 0);
    chk("reset done", int'(done), 0);
    rst = 1'b1;
    tick();

    for (int ch = 0; ch < CHANNELS; ch++) begin
      wr_sample(ch, 10, 40 + ch);
      wr_sample(ch, 11, 44 + ch);
      wr_dly(ch, 40);
      exp_v[ch] = 40 + ch;
    end
    run_pixel(0, "base");

    wr_sample(3, 10, 100);
    wr_sample(3, 11, -100);
    wr_dly(3, 41);
    wr_sample(7, 12, 1000);
    wr_dly(7, 46);
    wr_sample(9, 10, 0);
    wr_sample(9, 11, -3);
    wr_dly(9, 41);
    wr_dly(5, (DEPTH - 1) * 4);
`ifdef RF_INTERP_EN
    exp_v[3] = 50;
    exp_v[7] = 525;
    exp_v[9] = -1;
`else
    exp_v[3] = 100;
    exp_v[7] = 1000;
    exp_v[9] = 0;
`endif
    exp_v[5] = 0;
    run_pixel(0, "frac");

    dly_we = 1'b1; dly_ch = 8'd3; dly_val = 12'd43;
`ifdef RF_INTERP_EN
    exp_v[3] = -50;
`else
    exp_v[3] = -100;
`endif
    run_pixel(0, "simul");

    run_pixel(1, "disturb");
    run_pixel(0, "after_disturb");
    run_pixel(2, "abort");
    run_pixel(0, "restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
